mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Synchronous round-robin arbiter that shares the tarea3 2:1 `mux` output `y` between two requesters. It drives the mux select `s` and active-low output enable `notoe`, and returns one-hot grants to the requesters. Every owner change is break-before-make: `y` is tri-stated, `s` changes, `s` settles, then `y` is re-enabled. It sits between the requesting blocks and the `mux` instance, and it is the only driver of `s` and `notoe`.

## Interface
- `HOLD_MAX`, default 8: maximum cycles an owner keeps the mux while the other side is requesting. Legal range 1..255.
- `GUARD`, default 2: cycles `notoe` is held 1 on every handover. Legal range 2..15.

- `clk`  in  1  clock; all state changes on its rising edge.
- `notreset`  in  1  one clock; reset is synchronous and active-low.
- `req`  in  2  `req[i]`=1 means requester i wants input `a[i]` routed to `y`.
- `gnt`  out  2  one-hot grant; 00 when no owner.
- `s`  out  1  mux select; connects to `mux.s`.
- `notoe`  out  1  mux output enable, active-low; connects to `mux.notoe`.
- `preempt`  out  1  one-cycle pulse when an owner is forcibly removed.
- `swcount`  out  8  number of OWN entries since reset; saturates at 255.

## Operation
- All outputs are registered.
- Reset (`notreset`=0 at an edge) overrides all activity, including mid-OWN and mid-GUARD. After that edge:
  - state=IDLE, `s`=0, `notoe`=1, `gnt`=00, `preempt`=0, `swcount`=0;
  - internal `last`=1, so requester 0 wins the first tie;
  - hold and guard counters = 0.
- State IDLE: `notoe`=1, `gnt`=00.
  - If `req`≠00, select `next`: the single requester, or `~last` when `req`=11.
  - Enter GUARD.
- State GUARD: lasts exactly `GUARD` cycles; `notoe`=1, `gnt`=00.
  - `s`<=`next` at the first edge after entry, so `s` never changes on the same edge as `notoe`.
  - At the `GUARD`-th edge after entry:
    - if `req[next]`=1: enter OWN, `gnt[next]`=1, `notoe`=0, `last`<=`next`, `swcount`++ (saturating), hold counter cleared;
    - otherwise: enter IDLE with no grant and `swcount` unchanged.
- State OWN: `notoe`=0, `gnt` one-hot at owner `o`=`s`. The hold counter increments each cycle and saturates at `HOLD_MAX`.
  - `req[o]`=0 at an edge: release.
    - If `req[~o]`=1: enter GUARD with `next`=`~o`, `preempt`=0.
    - Else: enter IDLE.
  - `req[o]`=1, `req[~o]`=1, and hold counter ≥ `HOLD_MAX` at an edge: forced handover. Enter GUARD with `next`=`~o`, `preempt`=1 for that one cycle.
  - `req[~o]`=0: the owner keeps the mux indefinitely, with no timeout.
- On leaving OWN, `gnt`=00 and `notoe`=1 on the same edge.
- Invariants:
  - `s` changes only while `notoe`=1 and has been 1 for at least one cycle.
  - `gnt`≠00 exactly when `notoe`=0.
  - `gnt[s]`=1 whenever `gnt`≠00.

## Timing
- Request to grant, from IDLE: `req` sampled high at edge k → `gnt` high after edge k+`GUARD`. With the default, that is 2 cycles.
- Owner to owner handover: the exit edge e drops `gnt` and raises `notoe`; `s` flips after e+1; the new `gnt` appears after e+`GUARD`.
- Preempted owner: holds exactly `HOLD_MAX` cycles of `gnt`. Under constant contention, the period per owner is `HOLD_MAX`+`GUARD` cycles.
- Requests changing during GUARD are ignored except at its final edge.
- Releasing the mux costs zero extra cycles: `gnt` drops at the edge that samples `req[o]`=0.

## Test plan
- Reset: `notreset`=0 for 2 edges with `req`=11 → `s`=0, `notoe`=1, `gnt`=00, `preempt`=0, `swcount`=0; then `notreset`=1.
- Single request, defaults: `req`=01 sampled at edge k → `notoe`=1 through edge k+1; after k+2: `gnt`=01, `s`=0, `notoe`=0, `swcount`=1. Then `req`=00 → next edge `gnt`=00, `notoe`=1, IDLE.
- Contention, `HOLD_MAX`=8, `GUARD`=2, `req`=11 held from reset:
  - `gnt`=01 for 8 cycles, then `preempt` pulses once;
  - `gnt`=00 for 2 cycles, `s`=1 from the second of them;
  - `gnt`=10 for 8 cycles;
  - pattern repeats with period 20; `swcount` counts each grant and stops at 255.
- Voluntary release: owner 0 drops `req[0]` while `req[1]`=1 → GUARD toward 1 with `preempt`=0; `gnt`=10 two cycles later.
- Target withdraws: `req`=10 for one cycle only, from IDLE → GUARD completes, `s`=1, return to IDLE; `gnt` stays 00 and `swcount` is unchanged.
- Reset mid-OWN: `notreset`=0 at an edge while `gnt`=10 → after that edge `gnt`=00, `notoe`=1, `s`=0. A monitor over all tests flags any `s` change while `notoe`=0 and any non-one-hot `gnt`.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of a shared 2:1 mux output with break-before-make handover
module mux_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       notreset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       s,
  output logic       notoe,
  output logic       preempt,
  output logic [7:0] swcount
);
  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_OWN} state_t;
  state_t state;
  logic last, nxt;
  logic [7:0] hold;
  logic [3:0] gcnt;
  always_ff @(posedge clk) begin
    if (!notreset) begin
      state <= S_IDLE;
      s <= 1'b0;
      notoe <= 1'b1;
      gnt <= 2'b00;
      preempt <= 1'b0;
      swcount <= 8'd0;
      last <= 1'b1;
      nxt <= 1'b0;
      hold <= 8'd0;
      gcnt <= 4'd0;
    end else begin
      preempt <= 1'b0;
      case (state)
        S_IDLE: if (req != 2'b00) begin
          nxt <= (req == 2'b11) ? ~last : req[1];
          gcnt <= 4'd0;
          state <= S_GUARD;
        end
        S_GUARD: begin
          gcnt <= gcnt + 4'd1;
          if (gcnt == 4'd0) s <= nxt;
          if (gcnt == 4'(GUARD - 1)) begin
            if (req[nxt]) begin
              state <= S_OWN;
              gnt <= nxt ? 2'b10 : 2'b01;
              notoe <= 1'b0;
              last <= nxt;
              swcount <= (swcount == 8'd255) ? swcount : swcount + 8'd1;
              hold <= 8'd0;
            end else state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (hold < 8'(HOLD_MAX)) hold <= hold + 8'd1;
          // hold counts completed cycles, so the current one makes HOLD_MAX grant cycles
          if (!req[s] || (req[!s] && hold >= 8'(HOLD_MAX - 1))) begin
            gnt <= 2'b00;
            notoe <= 1'b1;
            if (req[!s]) begin
              nxt <= !s;
              gcnt <= 4'd0;
              state <= S_GUARD;
              preempt <= req[s];
            end else state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed vector table plus contention, saturation and invariant monitor
module tb_mux_arbiter;
  logic clk = 1'b0;
  logic notreset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic s, notoe, preempt;
  logic [7:0] swcount;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mux_arbiter #(.HOLD_MAX(8), .GUARD(2)) dut (
    .clk(clk), .notreset(notreset), .req(req), .gnt(gnt), .s(s),
    .notoe(notoe), .preempt(preempt), .swcount(swcount)
  );
  typedef struct {
    logic nr;
    logic [1:0] req;
    logic [1:0] gnt;
    logic s;
    logic notoe;
    logic pre;
    logic [7:0] sw;
  } vec_t;
  vec_t v[20];
  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  task automatic check_all(input int idx, input logic [1:0] eg, input logic es, input logic en, input logic ep, input logic [7:0] ew);
    check("gnt", idx, {6'd0, gnt}, {6'd0, eg});
    check("s", idx, {7'd0, s}, {7'd0, es});
    check("notoe", idx, {7'd0, notoe}, {7'd0, en});
    check("preempt", idx, {7'd0, preempt}, {7'd0, ep});
    check("swcount", idx, swcount, ew);
  endtask
  logic prev_s, prev_noe, rst_edge;
  logic mon_on = 1'b0;
  always @(posedge clk) begin
    rst_edge = !notreset;
    #2;
    if (mon_on && !rst_edge) begin
      n_cmp++;
      if ((s !== prev_s) && !(notoe === 1'b1 && prev_noe === 1'b1)) begin
        n_bad++;
        $display("FAIL mon_s_change: s %0b->%0b with notoe %0b (prev %0b), required notoe 1 for two cycles", prev_s, s, notoe, prev_noe);
      end
      n_cmp++;
      if (gnt === 2'b11 || ((gnt != 2'b00) !== (notoe == 1'b0)) || (gnt != 2'b00 && gnt[s] !== 1'b1)) begin
        n_bad++;
        $display("FAIL mon_gnt: gnt %b s %b notoe %b, required one-hot gnt at s exactly when notoe 0", gnt, s, notoe);
      end
    end
    prev_s = s;
    prev_noe = notoe;
  end
  initial begin
    v[0]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[1]  = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[2]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[3]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[4]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 8'd1};
    v[5]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1};
    v[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1};
    v[7]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1};
    v[8]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd1};
    v[9]  = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 8'd2};
    v[10] = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 8'd2};
    v[11] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 8'd2};
    v[12] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 8'd2};
    v[13] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 8'd3};
    v[14] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 8'd3};
    v[15] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[16] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0};
    v[17] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0};
    v[18] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0};
    v[19] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 8'd0};
    for (int i = 0; i < 20; i++) begin
      notreset = v[i].nr;
      req = v[i].req;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      check_all(i, v[i].gnt, v[i].s, v[i].notoe, v[i].pre, v[i].sw);
    end
    notreset = 1'b0;
    req = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check_all(100, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    notreset = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic [1:0] eg;
      logic es, ep;
      logic [7:0] ew;
      int u;
      @(posedge clk);
      #1;
      u = (t - 2) % 20;
      eg = 2'b00;
      es = 1'b0;
      ep = 1'b0;
      ew = 8'd0;
      if (t >= 2) begin
        ew = 8'((t - 2) / 10 + 1);
        if (u < 8) eg = 2'b01;
        else if (u == 8) ep = 1'b1;
        else if (u == 9) es = 1'b1;
        else if (u < 18) begin
          eg = 2'b10;
          es = 1'b1;
        end else if (u == 18) begin
          ep = 1'b1;
          es = 1'b1;
        end
      end
      check_all(200 + t, eg, es, (eg == 2'b00), ep, ew);
    end
    repeat (2600) @(posedge clk);
    #1;
    check("swcount_sat", 300, swcount, 8'd255);
    notreset = 1'b0;
    @(posedge clk);
    #1;
    check_all(301, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
